mem_burst_arbiter: RTL and testbench

//   Parametrised successor to the 2-bit/7-cell memory controller. Arbitrates VGA read bursts

---
 rtl/mem_burst_arbiter_if.sv | 34 +++
 rtl/mem_burst_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_arbiter_if.sv
// Request/response and single-port cell-memory signals of mem_burst_arbiter.
// The master modport is the arbiter side; slave is the requester/memory side.
interface mem_burst_arbiter_if #(
    parameter int CELL_W = 2,
    parameter int BURST  = 7,
    parameter int ADDR_W = 6
);
    logic                    rden_vga;
    logic [ADDR_W-1:0]       addr_vga;
    logic                    ready_vga;
    logic                    rden_ctl;
    logic                    wren_ctl;
    logic [ADDR_W-1:0]       addr_ctl;
    logic [CELL_W*BURST-1:0] wdata_ctl;
    logic                    ready_ctl;
    logic [CELL_W*BURST-1:0] data_c_m;
    logic                    busy;
    logic [ADDR_W-1:0]       addr;
    logic                    r_en;
    logic                    w_en;
    logic                    clk_m;
    logic [CELL_W-1:0]       q;
    logic [CELL_W-1:0]       q_out;

    modport master (
        input  rden_vga, addr_vga, rden_ctl, wren_ctl, addr_ctl, wdata_ctl, q,
        output ready_vga, ready_ctl, data_c_m, busy, addr, r_en, w_en, clk_m, q_out
    );

    modport slave (
        output rden_vga, addr_vga, rden_ctl, wren_ctl, addr_ctl, wdata_ctl, q,
        input  ready_vga, ready_ctl, data_c_m, busy, addr, r_en, w_en, clk_m, q_out
    );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Burst arbiter between VGA reads and controller reads/writes, driving a
// single-port cell memory with a three-phase strobe per cell.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | sample requests, grant and latch a burst
// R_SETUP  | read cell k: address and r_en set up
// R_STROBE | read cell k: clk_m high
// R_CAPT   | read cell k: q captured into cell k at cycle end
// W_SETUP  | write cell k: address, data and w_en set up
// W_STROBE | write cell k: clk_m high
// W_HOLD   | write cell k: data held after strobe
// DONE     | one-cycle ready pulse to the granted source
module mem_burst_arbiter #(
    parameter int CELL_W  = 2,
    parameter int BURST   = 7,
    parameter int ADDR_W  = 6,
    parameter int RR_MODE = 1
) (
    input logic                 clk,
    input logic                 reset,
    mem_burst_arbiter_if.master bus
);
    localparam int K_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BURST - 1);

    typedef enum logic [2:0] {
        IDLE, R_SETUP, R_STROBE, R_CAPT, W_SETUP, W_STROBE, W_HOLD, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [K_W-1:0]          k;
    logic [ADDR_W-1:0]       base;
    logic                    src_vga;
    logic                    last_vga;
    logic [CELL_W*BURST-1:0] wdata_q;
    logic [CELL_W*BURST-1:0] data_q;
    logic [CELL_W-1:0]       wcell;
    logic                    ctl_req;
    logic                    grant_vga;
    logic                    grant_ctl;
    logic                    k_last;

    // On a tie, round-robin hands the grant to whichever side did not win last.
    always_comb begin
        ctl_req = bus.rden_ctl | bus.wren_ctl;
        if (bus.rden_vga && ctl_req)
            grant_vga = (RR_MODE == 0) ? 1'b1 : ~last_vga;
        else
            grant_vga = bus.rden_vga;
        grant_ctl = ctl_req & ~grant_vga;
        k_last    = (k == K_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_vga || (grant_ctl && bus.rden_ctl))
                    state_nxt = R_SETUP;
                else if (grant_ctl)
                    state_nxt = W_SETUP;
            end
            R_SETUP:  state_nxt = R_STROBE;
            R_STROBE: state_nxt = R_CAPT;
            R_CAPT:   state_nxt = k_last ? DONE : R_SETUP;
            W_SETUP:  state_nxt = W_STROBE;
            W_STROBE: state_nxt = W_HOLD;
            W_HOLD:   state_nxt = k_last ? DONE : W_SETUP;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k        <= '0;
            base     <= '0;
            src_vga  <= 1'b0;
            last_vga <= 1'b0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vga || grant_ctl) begin
                        k        <= '0;
                        base     <= grant_vga ? bus.addr_vga : bus.addr_ctl;
                        src_vga  <= grant_vga;
                        last_vga <= grant_vga;
                        if (grant_ctl && !bus.rden_ctl)
                            wdata_q <= bus.wdata_ctl;
                    end
                end
                R_CAPT: begin
                    for (int i = 0; i < BURST; i++)
                        if (k == K_W'(i))
                            data_q[i*CELL_W +: CELL_W] <= bus.q;
                    if (!k_last)
                        k <= k + K_W'(1);
                end
                W_HOLD: begin
                    if (!k_last)
                        k <= k + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wcell = '0;
        for (int i = 0; i < BURST; i++)
            if (k == K_W'(i))
                wcell = wdata_q[i*CELL_W +: CELL_W];
    end

    // Address wraps naturally at 2**ADDR_W through the truncating add.
    always_comb begin
        bus.ready_vga = 1'b0;
        bus.ready_ctl = 1'b0;
        bus.busy      = (state != IDLE);
        bus.addr      = '0;
        bus.r_en      = 1'b0;
        bus.w_en      = 1'b0;
        bus.clk_m     = 1'b0;
        bus.q_out     = '0;
        case (state)
            R_SETUP, R_CAPT: begin
                bus.r_en = 1'b1;
                bus.addr = base + ADDR_W'(k);
            end
            R_STROBE: begin
                bus.r_en  = 1'b1;
                bus.clk_m = 1'b1;
                bus.addr  = base + ADDR_W'(k);
            end
            W_SETUP, W_HOLD: begin
                bus.w_en  = 1'b1;
                bus.addr  = base + ADDR_W'(k);
                bus.q_out = wcell;
            end
            W_STROBE: begin
                bus.w_en  = 1'b1;
                bus.clk_m = 1'b1;
                bus.addr  = base + ADDR_W'(k);
                bus.q_out = wcell;
            end
            DONE: begin
                bus.ready_vga = src_vga;
                bus.ready_ctl = ~src_vga;
            end
            default: ;
        endcase
    end

    assign bus.data_c_m = data_q;
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: a driver plans expected bursts from a
// behavioural memory/arbitration model, a monitor checks each ready pulse.
module tb_mem_burst_arbiter;
    localparam int CW  = 2;
    localparam int BU  = 7;
    localparam int AW  = 6;
    localparam int W   = CW * BU;
    localparam int NM  = 2 ** AW;
    localparam int LAT = 3 * BU + 1;

    typedef struct {
        logic          vga;
        logic          rd;
        logic [AW-1:0] base;
        logic [W-1:0]  data;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_burst_arbiter_if #(.CELL_W(CW), .BURST(BU), .ADDR_W(AW)) bus ();
    mem_burst_arbiter_if #(.CELL_W(CW), .BURST(BU), .ADDR_W(AW)) bus0 ();

    mem_burst_arbiter #(.CELL_W(CW), .BURST(BU), .ADDR_W(AW), .RR_MODE(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );
    mem_burst_arbiter #(.CELL_W(CW), .BURST(BU), .ADDR_W(AW), .RR_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.master)
    );

    // Fixed-priority instance reads a pattern memory and never writes.
    assign bus0.q         = bus0.addr[CW-1:0];
    assign bus0.wren_ctl  = 1'b0;
    assign bus0.addr_vga  = AW'(5);
    assign bus0.addr_ctl  = AW'(9);
    assign bus0.wdata_ctl = '0;

    logic [CW-1:0] mem     [NM];
    logic [CW-1:0] ref_mem [NM];
    assign bus.q = mem[bus.addr];

    initial begin
        for (int n = 0; n < NM; n++) mem[n] = CW'(n % 4);
        forever begin
            @(posedge bus.clk_m);
            if (bus.w_en) mem[bus.addr] = bus.q_out;
        end
    end

    int           n_cmp = 0;
    int           n_err = 0;
    exp_t         exp_q[$];
    logic         last_vga_m;
    logic [W-1:0] held_exp;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] b);
        logic [W-1:0] d;
        for (int i = 0; i < BU; i++) d[i*CW +: CW] = ref_mem[(int'(b) + i) % NM];
        return d;
    endfunction

    function automatic logic [W-1:0] mem_word(input logic [AW-1:0] b);
        logic [W-1:0] d;
        for (int i = 0; i < BU; i++) d[i*CW +: CW] = mem[(int'(b) + i) % NM];
        return d;
    endfunction

    // Service order: ctl read before ctl write; on a VGA/ctl tie the side not
    // served last goes first.
    task automatic plan(input logic pv, input logic pr, input logic pw,
                        input logic [AW-1:0] av, input logic [AW-1:0] ac,
                        input logic [W-1:0] wd);
        exp_t e;
        while (pv || pr || pw) begin
            if (pv && (!(pr || pw) || !last_vga_m)) begin
                e = '{1'b1, 1'b1, av, model_read(av)};
                pv = 1'b0; last_vga_m = 1'b1;
            end else if (pr) begin
                e = '{1'b0, 1'b1, ac, model_read(ac)};
                pr = 1'b0; last_vga_m = 1'b0;
            end else begin
                for (int i = 0; i < BU; i++) ref_mem[(int'(ac) + i) % NM] = wd[i*CW +: CW];
                e = '{1'b0, 1'b0, ac, wd};
                pw = 1'b0; last_vga_m = 1'b0;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic txn(input logic pv, input logic pr, input logic pw,
                       input logic [AW-1:0] av, input logic [AW-1:0] ac,
                       input logic [W-1:0] wd);
        int cyc = 0;
        plan(pv, pr, pw, av, ac, wd);
        bus.rden_vga  = pv;
        bus.rden_ctl  = pr;
        bus.wren_ctl  = pw;
        bus.addr_vga  = av;
        bus.addr_ctl  = ac;
        bus.wdata_ctl = wd;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.ready_vga) bus.rden_vga = 1'b0;
            if (bus.ready_ctl) begin
                if (bus.rden_ctl) bus.rden_ctl = 1'b0;
                else              bus.wren_ctl = 1'b0;
            end
        end while ((bus.rden_vga || bus.rden_ctl || bus.wren_ctl || bus.busy) && cyc < 400);
        if (cyc >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL txn_timeout: still busy after %0d cycles at %0t", cyc, $time);
            bus.rden_vga = 1'b0; bus.rden_ctl = 1'b0; bus.wren_ctl = 1'b0;
        end
    endtask

    // Monitor: pops one expectation per ready pulse; checks held data otherwise.
    initial begin
        exp_t e;
        int   lat;
        int   strb;
        lat = 0; strb = 0;
        held_exp = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                held_exp = '0; lat = 0; strb = 0;
            end else begin
                chk("en_exclusive", 64'(bus.r_en & bus.w_en), 64'(0));
                lat = bus.busy ? lat + 1 : 0;
                if (!bus.busy)      strb = 0;
                else if (bus.clk_m) strb++;
                if (bus.ready_vga || bus.ready_ctl) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ready: vga=%0b ctl=%0b at %0t",
                                 bus.ready_vga, bus.ready_ctl, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ready_source", 64'({bus.ready_vga, bus.ready_ctl}), 64'({e.vga, ~e.vga}));
                        chk("latency", 64'(lat), 64'(LAT));
                        chk("strobes", 64'(strb), 64'(BU));
                        if (e.rd) begin
                            chk("read_data", 64'(bus.data_c_m), 64'(e.data));
                            held_exp = e.data;
                        end else begin
                            chk("write_mem", 64'(mem_word(e.base)), 64'(e.data));
                        end
                    end
                end
                if (!bus.r_en) chk("data_held", 64'(bus.data_c_m), 64'(held_exp));
            end
        end
    end

    initial begin
        int           cyc;
        int           nv;
        int           nc;
        logic [W-1:0] w;
        logic         pv, pr, pw;
        for (int n = 0; n < NM; n++) ref_mem[n] = CW'(n % 4);
        last_vga_m    = 1'b0;
        bus.rden_vga  = 1'b0;
        bus.rden_ctl  = 1'b0;
        bus.wren_ctl  = 1'b0;
        bus.addr_vga  = '0;
        bus.addr_ctl  = '0;
        bus.wdata_ctl = '0;
        bus0.rden_vga = 1'b0;
        bus0.rden_ctl = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({bus.ready_vga, bus.ready_ctl, bus.busy, bus.r_en, bus.w_en,
                                  bus.clk_m, bus.addr, bus.q_out}), 64'(0));
        chk("reset_data", 64'(bus.data_c_m), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        txn(1'b1, 1'b0, 1'b0, AW'(10), '0, '0);
        chk("vga_read_a10", 64'(bus.data_c_m), 64'(14'h0E4E));

        txn(1'b0, 1'b0, 1'b1, '0, AW'(60), 14'h3FFF);
        chk("wrap_cell0", 64'(mem[0]), 64'(3));
        chk("wrap_cell2", 64'(mem[2]), 64'(3));
        chk("wrap_cell60", 64'(mem[60]), 64'(3));
        chk("wrap_untouched4", 64'(mem[4]), 64'(0));
        chk("data_after_write", 64'(bus.data_c_m), 64'(14'h0E4E));

        txn(1'b0, 1'b1, 1'b1, '0, AW'(30), 14'h1B2D);
        txn(1'b1, 1'b1, 1'b0, AW'(3), AW'(40), '0);
        txn(1'b1, 1'b1, 1'b0, AW'(50), AW'(12), '0);

        // Abort a VGA read in the strobe of cell 3.
        bus.rden_vga = 1'b1;
        bus.addr_vga = AW'(20);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(bus.r_en && bus.clk_m && bus.addr == AW'(23)) && cyc < 100);
        chk("abort_reached_strobe3", 64'(bus.addr), 64'(23));
        reset        = 1'b0;
        bus.rden_vga = 1'b0;
        last_vga_m   = 1'b0;
        #1;
        chk("abort_outputs", 64'({bus.ready_vga, bus.ready_ctl, bus.busy, bus.r_en, bus.w_en,
                                  bus.clk_m, bus.addr, bus.q_out}), 64'(0));
        chk("abort_data", 64'(bus.data_c_m), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        txn(1'b1, 1'b0, 1'b0, AW'(20), '0, '0);

        w = model_read(AW'(33));
        txn(1'b1, 1'b0, 1'b0, AW'(33), '0, '0);
        txn(1'b0, 1'b0, 1'b1, '0, AW'(8), 14'h2A55);
        repeat (5) @(negedge clk);
        chk("held_after_write_idle", 64'(bus.data_c_m), 64'(w));

        // Fixed VGA priority with both sides held: ctl never served.
        nv = 0; nc = 0;
        bus0.rden_vga = 1'b1;
        bus0.rden_ctl = 1'b1;
        repeat (120) begin
            @(negedge clk);
            if (bus0.ready_vga) nv++;
            if (bus0.ready_ctl) nc++;
        end
        bus0.rden_vga = 1'b0;
        bus0.rden_ctl = 1'b0;
        chk("fixed_prio_ctl_starved", 64'(nc), 64'(0));
        chk("fixed_prio_vga_count", 64'(nv), 64'(5));

        for (int t = 0; t < 30; t++) begin
            pv = 1'($urandom_range(0, 1));
            pr = 1'($urandom_range(0, 1));
            pw = 1'($urandom_range(0, 1));
            if (!(pv || pr || pw)) pv = 1'b1;
            txn(pv, pr, pw, AW'($urandom), AW'($urandom), W'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
